// File: rtl/cnt_ser_readout.sv
// cnt_ser_readout: SPI-side receiver for one channel's counter serial port.
// Loads the channel's seven frame bytes one at a time (SELECT_REG/LOAD_CNT_SER),
// deserialises each LSB-first byte from CNT_SER and, once the whole 56-bit
// frame {6'b0, CE, CD, CC, CB, CA} has arrived, presents the five counters in
// parallel with a one-cycle DATA_VALID pulse.
// Optional feature: define CNT_SER_READOUT_FRAME_CHK_EN to flag non-zero
// padding bits (frame[55:50]) on FRAME_ERR; otherwise FRAME_ERR is tied low.
//
// Handshake: REQ is a level sampled on rising SPI_CLK; it is accepted only in
// IDLE (BUSY=0), so REQ while BUSY is ignored and a REQ held high restarts on
// the first IDLE cycle. DATA_VALID is a single-cycle pulse with CA..CE stable
// from that cycle until the next pulse.
module cnt_ser_readout #(
    parameter int NUM_BYTES = 7,
    parameter int CNT_W     = 10
) (
    input  logic             SPI_CLK,
    input  logic             RSTB,
    input  logic             REQ,
    input  logic             CNT_SER,
    output logic             LOAD_CNT_SER,
    output logic [2:0]       SELECT_REG,
    output logic             BUSY,
    output logic             DATA_VALID,
    output logic [CNT_W-1:0] CA,
    output logic [CNT_W-1:0] CB,
    output logic [CNT_W-1:0] CC,
    output logic [CNT_W-1:0] CD,
    output logic [CNT_W-1:0] CE,
    output logic             FRAME_ERR,
    output logic [1:0]       STATE_DBG
);

    localparam int FRAME_W = NUM_BYTES * 8;
    // The last frame bit is taken straight from CNT_SER on the final edge,
    // so the shift register only needs to hold the preceding bits.
    localparam int SR_W = FRAME_W - 1;
    localparam logic [2:0] LAST_BYTE = 3'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FILL  = 2'd2,
        ST_SHIFT = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      byte_q, byte_d;
    logic [2:0]      bit_q, bit_d;
    logic [SR_W-1:0] sr_q, sr_d;
    logic            frame_done;

    // FSM state, byte index, bit count and shift register.
    always_ff @(posedge SPI_CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q <= ST_IDLE;
            byte_q  <= 3'd0;
            bit_q   <= 3'd0;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
        end
    end

    // Next-state logic: LOAD and FILL take one cycle each, SHIFT takes eight,
    // giving a fixed ten-cycle byte period.
    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        bit_d      = bit_q;
        sr_d       = sr_q;
        frame_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (REQ) begin
                    state_d = ST_LOAD;
                    byte_d  = 3'd0;
                    sr_d    = '0;
                end
            end
            ST_LOAD: begin
                state_d = ST_FILL;
            end
            ST_FILL: begin
                // The channel launches bit0 on the edge that leaves FILL.
                state_d = ST_SHIFT;
                bit_d   = 3'd0;
            end
            ST_SHIFT: begin
                // LSB-first: older bits drift toward index 0.
                sr_d = {CNT_SER, sr_q[SR_W-1:1]};
                if (bit_q == 3'd7) begin
                    if (byte_q == LAST_BYTE) begin
                        state_d    = ST_IDLE;
                        frame_done = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                        byte_d  = byte_q + 3'd1;
                    end
                end else begin
                    bit_d = bit_q + 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Byte load strobe, launched on the falling edge so it straddles exactly
    // the one rising edge where the channel captures its byte.
    always_ff @(negedge SPI_CLK or negedge RSTB) begin
        if (!RSTB) begin
            LOAD_CNT_SER <= 1'b0;
        end else begin
            LOAD_CNT_SER <= (state_q == ST_LOAD);
        end
    end

    // Parallel counter outputs, updated together only when a full frame is in.
    always_ff @(posedge SPI_CLK or negedge RSTB) begin
        if (!RSTB) begin
            CA         <= '0;
            CB         <= '0;
            CC         <= '0;
            CD         <= '0;
            CE         <= '0;
            DATA_VALID <= 1'b0;
        end else begin
            DATA_VALID <= frame_done;
            if (frame_done) begin
                CA <= sr_q[0*CNT_W +: CNT_W];
                CB <= sr_q[1*CNT_W +: CNT_W];
                CC <= sr_q[2*CNT_W +: CNT_W];
                CD <= sr_q[3*CNT_W +: CNT_W];
                CE <= sr_q[4*CNT_W +: CNT_W];
            end
        end
    end

`ifdef CNT_SER_READOUT_FRAME_CHK_EN
    // Padding check: any set bit in frame[55:50] flags the frame; held until
    // the next completed frame.
    always_ff @(posedge SPI_CLK or negedge RSTB) begin
        if (!RSTB) begin
            FRAME_ERR <= 1'b0;
        end else if (frame_done) begin
            FRAME_ERR <= |{CNT_SER, sr_q[SR_W-1:5*CNT_W]};
        end
    end
`else
    assign FRAME_ERR = 1'b0;
`endif

    // SELECT_REG is the registered byte index; it keeps the last byte when idle.
    assign SELECT_REG = byte_q;
    assign BUSY       = (state_q != ST_IDLE);
    assign STATE_DBG  = state_q;

endmodule
